// File: rtl/iir_chan_sched_if.sv
// rtl/iir_chan_sched_if.sv - sample, engine and result signals of the channel scheduler
interface iir_chan_sched_if #(
    parameter int NCH = 2,
    parameter int DW  = 18,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
);
    logic [NCH-1:0]    in_valid;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_ready;

    logic              eng_start;
    logic [CW-1:0]     eng_chan;
    logic [DW-1:0]     eng_din;
    logic              eng_done;
    logic [DW-1:0]     eng_dout;

    logic [NCH-1:0]    out_valid;
    logic [NCH*DW-1:0] out_data;

    modport slave (
        input  in_valid, in_data, eng_done, eng_dout,
        output in_ready, eng_start, eng_chan, eng_din, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, eng_done, eng_dout,
        input  in_ready, eng_start, eng_chan, eng_din, out_valid, out_data
    );
endinterface

// File: rtl/iir_chan_sched.sv
// rtl/iir_chan_sched.sv - round-robin scheduler sharing one IIR engine between NCH channels
module iir_chan_sched #(
    parameter int NCH     = 2,
    parameter int DW      = 18,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    iir_chan_sched_if.slave bus,
    output logic            timeout_err,
    input  logic            err_clr
);
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNTW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t          state;
    logic [NCH-1:0]  pend;
    logic [DW-1:0]   sample_buf [NCH];
    logic [CW-1:0]   rr_last;
    logic [CNTW-1:0] wait_cnt;
    logic [CW-1:0]   grant;
    logic            grant_ok;
    int              idx;

    assign bus.in_ready = ~pend;

    // Search starts just after the last winner so every pending channel is served in turn.
    always_comb begin
        grant_ok = 1'b0;
        grant    = '0;
        idx      = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = int'(rr_last) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!grant_ok && pend[idx]) begin
                grant_ok = 1'b1;
                grant    = CW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            pend          <= '0;
            rr_last       <= CW'(NCH - 1);
            wait_cnt      <= '0;
            timeout_err   <= 1'b0;
            bus.eng_start <= 1'b0;
            bus.eng_chan  <= '0;
            bus.eng_din   <= '0;
            bus.out_valid <= '0;
            bus.out_data  <= '0;
            for (int i = 0; i < NCH; i++) sample_buf[i] <= '0;
        end else begin
            bus.out_valid <= '0;
            for (int i = 0; i < NCH; i++) begin
                if (bus.in_valid[i] && !pend[i]) begin
                    sample_buf[i] <= bus.in_data[i*DW +: DW];
                    pend[i]       <= 1'b1;
                end
            end
            if (err_clr) timeout_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (grant_ok) begin
                        bus.eng_chan  <= grant;
                        bus.eng_din   <= sample_buf[grant];
                        pend[grant]   <= 1'b0;
                        rr_last       <= grant;
                        bus.eng_start <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    bus.eng_start <= 1'b0;
                    wait_cnt      <= '0;
                    state         <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.eng_done) begin
                        bus.out_data[int'(bus.eng_chan)*DW +: DW] <= bus.eng_dout;
                        bus.out_valid[bus.eng_chan]               <= 1'b1;
                        state                                     <= S_IDLE;
                    end else if (wait_cnt == CNTW'(TIMEOUT - 1)) begin
                        // Sample is dropped; a late result lands in IDLE and is ignored.
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iir_chan_sched.sv
// tb/tb_iir_chan_sched.sv - directed bench for iir_chan_sched with a latency-4 engine model
module tb_iir_chan_sched;
    localparam int NCH = 2;
    localparam int DW  = 18;
    localparam int TO  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          err_clr = 1'b0;
    logic          timeout_err;
    logic [1:0]    in_valid = 2'b00;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic          m_done = 1'b0, x_done = 1'b0;
    logic [DW-1:0] m_dout = '0, x_dout = '0;
    logic [DW-1:0] eng_lat = '0;
    bit            eng_en = 1'b1;
    int            eng_cnt = 0;
    int            checks = 0, failures = 0;
    int            c;

    always #5 clk = ~clk;

    iir_chan_sched_if #(.NCH(NCH), .DW(DW)) bus ();

    assign bus.in_valid = in_valid;
    assign bus.in_data  = {d1, d0};
    assign bus.eng_done = m_done | x_done;
    assign bus.eng_dout = x_done ? x_dout : m_dout;

    iir_chan_sched #(.NCH(NCH), .DW(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    // Engine: done pulse 4 cycles after the start cycle, result = din + 1.
    always @(negedge clk) begin
        m_done = 1'b0;
        if (!rst_n) begin
            eng_cnt = 0;
        end else begin
            if (eng_cnt > 0) begin
                eng_cnt = eng_cnt - 1;
                if (eng_cnt == 0) begin
                    m_done = 1'b1;
                    m_dout = eng_lat + 1'b1;
                end
            end
            if (eng_en && bus.eng_start) begin
                eng_cnt = 4;
                eng_lat = bus.eng_din;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(input string tag);
        int w;
        w = 0;
        while (bus.eng_start !== 1'b1 && w < 30) begin
            tick(1);
            w++;
        end
        chk(tag, bus.eng_start, 1);
    endtask

    initial begin
        tick(2);
        chk("rst_in_ready", bus.in_ready, 2'b11);
        chk("rst_eng_start", bus.eng_start, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_eng_chan", bus.eng_chan, 0);
        rst_n = 1'b1;
        tick(1);

        // single sample on ch0
        d0 = 18'h00100; in_valid = 2'b01;
        tick(1); in_valid = 2'b00;
        chk("t1_pend", bus.in_ready, 2'b10);
        chk("t1_no_start", bus.eng_start, 0);
        tick(1);
        chk("t1_start", bus.eng_start, 1);
        chk("t1_chan", bus.eng_chan, 0);
        chk("t1_din", bus.eng_din, 18'h00100);
        chk("t1_ready_issue", bus.in_ready[0], 1);
        tick(1);
        chk("t1_start_pulse", bus.eng_start, 0);
        tick(3);
        chk("t1_ov_early", bus.out_valid, 0);
        tick(1);
        chk("t1_ov", bus.out_valid, 2'b01);
        chk("t1_od0", bus.out_data[DW-1:0], 18'h00101);
        tick(1);
        chk("t1_ov_once", bus.out_valid, 0);
        chk("t1_od0_hold", bus.out_data[DW-1:0], 18'h00101);

        // fresh reset, both channels continuously pending
        rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
        d0 = 18'h00200; d1 = 18'h00300; in_valid = 2'b11;
        tick(1);
        chk("t2_both_pend", bus.in_ready, 2'b00);
        for (int j = 0; j < 6; j++) begin
            wait_start($sformatf("t2_start%0d", j));
            c = j % 2;
            chk($sformatf("t2_chan%0d", j), bus.eng_chan, c);
            chk($sformatf("t2_din%0d", j), bus.eng_din, (c == 1 ? 18'h00300 : 18'h00200) + j / 2);
            chk($sformatf("t2_ready%0d", j), bus.in_ready[c], 1);
            if (c == 0) d0 = d0 + 1'b1; else d1 = d1 + 1'b1;
            if (j == 5) in_valid = 2'b00;
            tick(1);
        end
        wait_start("t2_drain_start");
        chk("t2_drain_chan", bus.eng_chan, 0);
        chk("t2_drain_din", bus.eng_din, 18'h00203);
        tick(10);
        chk("t2_od0", bus.out_data[DW-1:0], 18'h00204);
        chk("t2_od1", bus.out_data[2*DW-1:DW], 18'h00303);

        // ch1 held valid while its buffer is full
        d0 = 18'h00400; in_valid = 2'b01;
        tick(1);
        d1 = 18'h00500; in_valid = 2'b10;
        tick(1);
        chk("t3_start0", bus.eng_start, 1);
        chk("t3_chan0", bus.eng_chan, 0);
        d1 = 18'h005AA;
        tick(2);
        chk("t3_bp", bus.in_ready[1], 0);
        wait_start("t3_start1");
        chk("t3_chan1", bus.eng_chan, 1);
        chk("t3_din1", bus.eng_din, 18'h00500);
        chk("t3_ready1", bus.in_ready[1], 1);
        chk("t3_od0", bus.out_data[DW-1:0], 18'h00401);
        tick(1); in_valid = 2'b00;
        wait_start("t3_start2");
        chk("t3_chan2", bus.eng_chan, 1);
        chk("t3_din2", bus.eng_din, 18'h005AA);
        tick(8);
        chk("t3_od1", bus.out_data[2*DW-1:DW], 18'h005AB);

        // engine never answers
        eng_en = 1'b0;
        d0 = 18'h00600; in_valid = 2'b01;
        tick(1); in_valid = 2'b00;
        wait_start("t4_start");
        tick(TO);
        chk("t4_err_early", timeout_err, 0);
        tick(1);
        chk("t4_err", timeout_err, 1);
        chk("t4_no_ov", bus.out_valid, 0);
        x_dout = 18'h3FFFF; x_done = 1'b1;
        tick(1); x_done = 1'b0;
        chk("t4_late_ov", bus.out_valid, 0);
        chk("t4_late_od0", bus.out_data[DW-1:0], 18'h00401);
        chk("t4_err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        tick(1); err_clr = 1'b0;
        chk("t4_clr", timeout_err, 0);
        eng_en = 1'b1;
        d1 = 18'h00700; in_valid = 2'b10;
        tick(1); in_valid = 2'b00;
        wait_start("t4_recover");
        chk("t4_recover_chan", bus.eng_chan, 1);
        tick(8);

        // async reset in the middle of a WAIT
        eng_en = 1'b0;
        d0 = 18'h00800; d1 = 18'h00900; in_valid = 2'b11;
        tick(1); in_valid = 2'b00;
        wait_start("t5_start0");
        chk("t5_chan0", bus.eng_chan, 0);
        tick(TO + 1);
        chk("t5_err", timeout_err, 1);
        wait_start("t5_start1");
        chk("t5_chan1", bus.eng_chan, 1);
        d0 = 18'h00801; in_valid = 2'b01;
        tick(1); in_valid = 2'b00;
        chk("t5_pend", bus.in_ready, 2'b10);
        tick(1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", bus.in_ready, 2'b11);
        chk("t5_rst_start", bus.eng_start, 0);
        chk("t5_rst_ov", bus.out_valid, 0);
        chk("t5_rst_err", timeout_err, 0);
        chk("t5_rst_od", bus.out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        x_dout = 18'h00123; x_done = 1'b1;
        tick(1); x_done = 1'b0;
        chk("t5_late_ov", bus.out_valid, 0);
        chk("t5_late_od", bus.out_data, 0);
        tick(3);
        chk("t5_idle_start", bus.eng_start, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
